// File: rtl/param_stack_pkg.sv
// Shared types and sizing helpers for the parametrised LIFO.
// Operation codes are encoded as {push,pop} so a plain cast decodes them.
package stack_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_PUSH    = 2'b10,
        OP_POP     = 2'b01,
        OP_REPLACE = 2'b11
    } stack_op_t;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/param_stack_mem.sv
// Stack storage: DEPTH x WIDTH register file, one synchronous write port
// and one asynchronous read port. Contents are intentionally not reset.
module stack_mem #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO with registered top-of-stack peek, pop data strobe,
// same-cycle replace, occupancy count and sticky overflow/underflow flags.
module param_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 256,
    parameter int CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = addr_width(DEPTH);

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_top;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overflow;
    logic             r_underflow;

    stack_op_t        w_op;
    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_do_repl;
    logic             w_do_first;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;
    logic [AW-1:0]    w_rd_addr;
    logic [WIDTH-1:0] w_rd_data;

    always_comb begin
        w_op       = stack_op_t'({push, pop});
        w_empty    = (r_count == '0);
        w_full     = (r_count == CW'(DEPTH));
        w_do_push  = (w_op == OP_PUSH) && !w_full;
        w_do_pop   = (w_op == OP_POP) && !w_empty;
        w_do_repl  = (w_op == OP_REPLACE) && !w_empty;
        // Replace on an empty stack degenerates to a plain push.
        w_do_first = (w_op == OP_REPLACE) && w_empty;
        w_ovf_set  = (w_op == OP_PUSH) && w_full;
        w_unf_set  = ((w_op == OP_POP) || (w_op == OP_REPLACE)) && w_empty;
        w_wr_en    = (w_do_push || w_do_repl || w_do_first) && !rst;
        w_wr_addr  = w_do_repl ? AW'(r_count - CW'(1)) : AW'(r_count);
        // Entry just below the current top, used to refill top after a pop.
        w_rd_addr  = AW'(r_count - CW'(2));
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (w_wr_addr),
        .i_wdata (din),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_top        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_dout_valid <= w_do_pop || w_do_repl;
            if (w_do_pop || w_do_repl) begin
                r_dout <= r_top;
            end

            if (w_do_push || w_do_first) begin
                r_count <= r_count + CW'(1);
                r_top   <= din;
            end else if (w_do_repl) begin
                r_top   <= din;
            end else if (w_do_pop) begin
                r_count <= r_count - CW'(1);
                r_top   <= (r_count >= CW'(2)) ? w_rd_data : '0;
            end

            // An error in the same cycle as clr_err wins over the clear.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end

            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign top        = r_top;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign count      = r_count;
    assign empty      = w_empty;
    assign full       = w_full;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_param_stack.sv
// Bench for param_stack (WIDTH=8, DEPTH=4): directed operations, a dout
// scoreboard fed at issue time and drained by a dout_valid monitor.
module tb_param_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    param_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .din        (din),
        .clr_err    (clr_err),
        .top        (top),
        .dout       (dout),
        .dout_valid (dout_valid),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks: inputs applied just after an edge, held for one edge.
    task automatic op(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic c);
        push    = p;
        pop     = q;
        din     = d;
        clr_err = c;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        din     = '0;
        clr_err = 1'b0;
    endtask

    task automatic do_push(input logic [WIDTH-1:0] d);
        op(1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic do_pop(input logic [WIDTH-1:0] exp);
        exp_q.push_back(exp);
        op(1'b0, 1'b1, '0, 1'b0);
    endtask

    task automatic do_replace(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp);
        exp_q.push_back(exp);
        op(1'b1, 1'b1, d, 1'b0);
    endtask

    // Monitor: every dout_valid pulse must match the oldest expected value.
    always @(negedge clk) begin
        if (dout_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_dout_valid: got dout=0x%0h expected no pulse at %0t", dout, $time);
            end else begin
                chk("dout_scoreboard", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; din = '0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_count", 32'(count), 0);
        chk("rst_top", 32'(top), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_dout_valid", 32'(dout_valid), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_underflow", 32'(underflow), 0);

        // Basic push/pop ordering
        do_push(8'h11);
        chk("p1_top", 32'(top), 32'h11);
        do_push(8'h22);
        do_push(8'h33);
        chk("p3_count", 32'(count), 3);
        chk("p3_top", 32'(top), 32'h33);
        chk("p3_empty", 32'(empty), 0);
        chk("p3_full", 32'(full), 0);
        do_pop(8'h33);
        chk("pop1_dout_valid", 32'(dout_valid), 1);
        chk("pop1_top", 32'(top), 32'h22);
        do_pop(8'h22);
        do_pop(8'h11);
        chk("pop3_empty", 32'(empty), 1);
        chk("pop3_top", 32'(top), 0);
        chk("pop3_count", 32'(count), 0);

        // Fill, overflow, clear
        for (int i = 0; i < 4; i++) do_push(8'hA0 + 8'(i));
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 4);
        do_push(8'hFF);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_top", 32'(top), 32'hA3);
        op(1'b0, 1'b0, '0, 1'b1);
        chk("clr_overflow", 32'(overflow), 0);
        for (int i = 3; i >= 0; i--) do_pop(8'hA0 + 8'(i));
        chk("drain_empty", 32'(empty), 1);

        // Underflow and replace on an empty stack
        op(1'b0, 1'b1, '0, 1'b0);
        chk("unf_flag", 32'(underflow), 1);
        chk("unf_dout_valid", 32'(dout_valid), 0);
        chk("unf_count", 32'(count), 0);
        chk("unf_dout_held", 32'(dout), 32'hA0);
        op(1'b1, 1'b1, 8'h5A, 1'b0);
        chk("repl_empty_count", 32'(count), 1);
        chk("repl_empty_top", 32'(top), 32'h5A);
        chk("repl_empty_unf", 32'(underflow), 1);
        chk("repl_empty_dv", 32'(dout_valid), 0);
        op(1'b0, 1'b0, '0, 1'b1);
        chk("clr_underflow", 32'(underflow), 0);
        do_pop(8'h5A);

        // Replace on a partly filled stack
        do_push(8'h01);
        do_push(8'h02);
        do_replace(8'h99, 8'h02);
        chk("repl_dout", 32'(dout), 32'h02);
        chk("repl_dv", 32'(dout_valid), 1);
        chk("repl_top", 32'(top), 32'h99);
        chk("repl_count", 32'(count), 2);
        do_pop(8'h99);
        chk("repl_pop_dout", 32'(dout), 32'h99);
        chk("repl_pop_top", 32'(top), 32'h01);
        do_pop(8'h01);

        // Replace on a full stack
        for (int i = 1; i <= 4; i++) do_push(8'hC0 + 8'(i));
        do_replace(8'h77, 8'hC4);
        chk("repl_full_count", 32'(count), 4);
        chk("repl_full_top", 32'(top), 32'h77);
        chk("repl_full_ovf", 32'(overflow), 0);
        do_pop(8'h77);
        chk("repl_full_pop_top", 32'(top), 32'hC3);
        for (int i = 3; i >= 1; i--) do_pop(8'hC0 + 8'(i));

        // Error in the same cycle as clr_err: set wins
        op(1'b0, 1'b1, '0, 1'b1);
        chk("set_wins_unf", 32'(underflow), 1);

        // Reset mid-sequence discards the concurrent push
        do_push(8'h10);
        do_push(8'h20);
        rst = 1'b1;
        op(1'b1, 1'b0, 8'h30, 1'b0);
        rst = 1'b0;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_top", 32'(top), 0);
        chk("mid_rst_dout", 32'(dout), 0);
        chk("mid_rst_unf", 32'(underflow), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        op(1'b0, 1'b1, '0, 1'b0);
        chk("post_rst_unf", 32'(underflow), 1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/param_stack.md
# param_stack

Parametrised LIFO for the single-cycle RISC-V datapath and its control helpers, such as the return-address and branch-history stacks. It stores up to DEPTH entries of WIDTH bits and always presents the top entry as a registered peek value. It also returns popped data with a valid strobe and supports a same-cycle push+pop that replaces the top entry. Full/empty status, an occupancy count and sticky overflow/underflow error flags make it usable without external bookkeeping.

## Interface
- WIDTH, 2, data bits per entry (≥1)
- DEPTH, 256, number of entries (≥2)
- CW, $clog2(DEPTH+1), width of count (derived, not overridden)

- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high; dominates all other inputs
- push  input  1  write din onto stack
- pop  input  1  remove top entry
- din  input  WIDTH  push data
- clr_err  input  1  clear overflow/underflow
- top  output  WIDTH  registered copy of current top entry; 0 when empty
- dout  output  WIDTH  data removed by last accepted pop; holds until next accepted pop
- dout_valid  output  1  one-cycle pulse: dout updated this cycle
- count  output  CW  number of stored entries, 0..DEPTH
- empty  output  1  count == 0 (combinational from count)
- full  output  1  count == DEPTH (combinational from count)
- overflow  output  1  sticky: push rejected while full
- underflow  output  1  sticky: pop rejected while empty

## Operation
- Reset values: count=0, top=0, dout=0, dout_valid=0, overflow=0, underflow=0. Memory contents are not reset.
- Cases are decoded from {push,pop} and the pre-edge state:
  - Idle (00): nothing changes; dout_valid=0.
  - Push (10), not full: mem[count]←din, count+1, top←din.
  - Push (10), full: ignored; overflow←1.
  - Pop (01), not empty: dout←top, dout_valid←1, count−1; top←mem[count−2] if count≥2, else 0.
  - Pop (01), empty: ignored; underflow←1; dout unchanged.
  - Replace (11), not empty (including full): mem[count−1]←din, top←din, dout←old top, dout_valid←1, count unchanged. No overflow.
  - Replace (11), empty: the push executes (count 0→1, top←din). The pop is rejected, so underflow←1 and dout_valid=0.
- clr_err clears both sticky flags. If an error occurs in the same cycle, set wins over clear.
- count arithmetic is CW bits wide and never wraps. Guards prevent going above DEPTH or below 0.

## Timing
- All outputs except empty and full are registered, with 1-cycle latency: effects are visible after the edge that samples the request.
- top is valid in the cycle after a push; there is no read latency on the peek path.
- Back-to-back operations every cycle are legal with no bubbles. Example: push then pop returns the just-pushed value on the next edge.
- rst asserted mid-sequence returns to the reset state on that edge. Any push/pop in the same cycle is discarded.
- dout_valid is high for exactly one cycle per accepted pop or replace.

## Structure
- Shared package stack_pkg holds:
  - stack_op_t enum {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE}, decoded from {push,pop};
  - the count-width helper function.
- Sub-module stack_mem holds the storage: DEPTH×WIDTH register file with one synchronous write port and one asynchronous read port. It is addressed by count−1 for replace and count−2 for top refill.
- param_stack contains the op decode, count register, top/dout registers and error flags.

## Test plan
All scenarios use WIDTH=8, DEPTH=4.
- Reset then push 0x11, 0x22, 0x33 → count=3, top=0x33, empty=0, full=0; after 3 pops dout sequence 0x33, 0x22, 0x11, each with a dout_valid pulse, then empty=1, top=0.
- Push 0xA0..0xA3 → full=1. Push 0xFF → overflow=1, count=4, top=0xA3. Assert clr_err → overflow=0.
- Pop while empty → underflow=1, dout_valid=0, count=0. Then push+pop with din=0x5A → count=1, top=0x5A, underflow stays 1.
- Stack [0x01, 0x02] (top 0x02), push+pop din=0x99 → dout=0x02, dout_valid=1, top=0x99, count=2. Pop → dout=0x99, top=0x01.
- Full stack, push+pop din=0x77 → count=4, top=0x77, overflow=0.
- Push 0x10, 0x20, then rst asserted in the same cycle as push 0x30 → count=0, top=0, dout=0, flags=0. A following pop sets underflow.
